multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/opcode_decoder.sv | 21 ++
 rtl/multicycle_control.sv | 132 +++++++++++++
 tb/tb_multicycle_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU-control selects and the datapath mux encodings.
package mips_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_addiu;
    logic is_beq;
    logic is_j;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classification; anything outside the supported set is illegal.
module opcode_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls          = '0;
    cls.is_rtype = (opcode == OP_RTYPE);
    cls.is_lw    = (opcode == OP_LW);
    cls.is_sw    = (opcode == OP_SW);
    cls.is_addiu = (opcode == OP_ADDIU);
    cls.is_beq   = (opcode == OP_BEQ);
    cls.is_j     = (opcode == OP_J);
    cls.illegal  = ~(cls.is_rtype | cls.is_lw | cls.is_sw |
                     cls.is_addiu | cls.is_beq | cls.is_j);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory stall
// support and a retired-instruction counter.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        waitrequest,
  input  logic        alu_zero,
  output logic [2:0]  aluOp,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        active,
  output logic [31:0] retired,
  output logic [2:0]  state_o
);

  state_t    state_q, state_nxt;
  op_class_t cls;
  logic [31:0] retired_q;
  logic        retire;

  // funct is consumed by the downstream ALU-control block (aluOp=010)
  logic unused_funct;
  assign unused_funct = ^funct;

  opcode_decoder u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  always_comb begin
    state_nxt  = S_HALT;
    aluOp      = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ~waitrequest;
        pc_write  = ~waitrequest;
        state_nxt = waitrequest ? S_FETCH : S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        state_nxt = cls.illegal ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (cls.is_rtype) begin
          alu_src_a = 1'b1;
          aluOp     = ALU_FUNCT;
          state_nxt = S_WB;
        end else if (cls.is_lw || cls.is_sw || cls.is_addiu) begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_nxt = cls.is_addiu ? S_WB : S_MEM;
        end else if (cls.is_beq) begin
          alu_src_a = 1'b1;
          aluOp     = ALU_SUB;
          pc_source = PCSRC_ALUOUT;
          pc_write  = alu_zero;
          state_nxt = S_FETCH;
        end else if (cls.is_j) begin
          pc_source = PCSRC_JUMP;
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = cls.is_lw;
        mem_write = cls.is_sw;
        if (waitrequest) state_nxt = S_MEM;
        else             state_nxt = cls.is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = cls.is_rtype;
        mem_to_reg = cls.is_lw;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
    // reset kills every strobe immediately, even mid-stall
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign retire = (state_nxt == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign active  = (state_q != S_HALT);
  assign retired = retired_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state outputs, stalls, CPI, halt,
// async reset abort and retired-counter wrap.
module tb_multicycle_control;
  import mips_pkg::*;

  logic        clk, rst_n;
  logic [5:0]  opcode, funct;
  logic        waitrequest, alu_zero;
  logic [2:0]  aluOp;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic        i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic        active;
  logic [31:0] retired;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic viol;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .waitrequest(waitrequest), .alu_zero(alu_zero), .aluOp(aluOp),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .active(active),
    .retired(retired), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH until retired moves; stall counts are
  // applied to the first fw FETCH cycles and first mw MEM cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int n);
    int f, m;
    logic [31:0] r0;
    f = 0; m = 0; n = 0;
    r0 = retired;
    opcode = op;
    while (retired == r0 && n < 60) begin
      if (state_o == S_FETCH)    begin waitrequest = (f < fw); f++; end
      else if (state_o == S_MEM) begin waitrequest = (m < mw); m++; end
      else                       waitrequest = 1'b0;
      #1;
      if (mem_read && mem_write) viol = 1'b1;
      if (reg_write && mem_write) viol = 1'b1;
      if (waitrequest && state_o == S_FETCH) begin
        chk("fetch_stall_rd", {mem_read, ir_write, pc_write}, 3'b100);
      end
      if (waitrequest && state_o == S_MEM) begin
        chk("mem_stall", {i_or_d, mem_read, mem_write},
            {1'b1, op == OP_LW, op == OP_SW});
      end
      if (state_o == S_WB && op == OP_LW) chk("lw_wb_mtr", {reg_write, mem_to_reg}, 2'b11);
      step();
      n++;
    end
    waitrequest = 1'b0;
    if (n >= 60) chk("instr_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    viol = 1'b0;
    rst_n = 1'b0; opcode = OP_RTYPE; funct = 6'b100000;
    waitrequest = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, S_FETCH);
    chk("rst_retired", retired, 32'd0);
    chk("rst_active", active, 1'b1);
    chk("rst_strobes", {mem_read, mem_write, ir_write, pc_write, reg_write}, 5'b0);
    rst_n = 1'b1;
    #1;

    // R-type walk-through
    chk("r_fetch", {state_o, mem_read, ir_write, pc_write, i_or_d, alu_src_a, alu_src_b, aluOp, pc_source},
        {S_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SRCB_FOUR, ALU_ADD, PCSRC_ALU});
    step();
    chk("r_decode", {state_o, alu_src_a, alu_src_b, aluOp}, {S_DECODE, 1'b0, SRCB_IMM_SH2, ALU_ADD});
    step();
    chk("r_exec", {state_o, alu_src_a, alu_src_b, aluOp}, {S_EXEC, 1'b1, SRCB_REGB, ALU_FUNCT});
    step();
    chk("r_wb", {state_o, reg_write, reg_dst, mem_to_reg}, {S_WB, 1'b1, 1'b1, 1'b0});
    chk("r_wb_retired", retired, 32'd0);
    step();
    chk("r_back_fetch", state_o, S_FETCH);
    chk("r_retired", retired, 32'd1);

    // CPI table, zero wait states
    run_instr(OP_RTYPE, 0, 0, cyc); chk("cpi_r", cyc, 4);
    run_instr(OP_ADDIU, 0, 0, cyc); chk("cpi_addiu", cyc, 4);
    run_instr(OP_LW,    0, 0, cyc); chk("cpi_lw", cyc, 5);
    run_instr(OP_SW,    0, 0, cyc); chk("cpi_sw", cyc, 4);
    run_instr(OP_BEQ,   0, 0, cyc); chk("cpi_beq", cyc, 3);
    run_instr(OP_J,     0, 0, cyc); chk("cpi_j", cyc, 3);
    chk("retired_7", retired, 32'd7);

    // LW with 2 fetch and 3 memory stall cycles
    run_instr(OP_LW, 2, 3, cyc); chk("lw_stall_cyc", cyc, 10);
    run_instr(OP_SW, 1, 2, cyc); chk("sw_stall_cyc", cyc, 7);

    // BEQ taken then not taken
    for (int z = 1; z >= 0; z--) begin
      opcode = OP_BEQ; alu_zero = z[0];
      step(); step();
      chk("beq_exec", {state_o, aluOp, pc_source, alu_src_a, alu_src_b, pc_write},
          {S_EXEC, ALU_SUB, PCSRC_ALUOUT, 1'b1, SRCB_REGB, z[0]});
      step();
      chk("beq_fetch", state_o, S_FETCH);
    end
    chk("retired_11", retired, 32'd11);
    chk("no_conflict", viol, 1'b0);

    // illegal opcode halts until reset
    opcode = 6'b111111;
    step(); step();
    chk("halt_state", state_o, S_HALT);
    begin
      logic hviol;
      hviol = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (active || mem_read || mem_write || ir_write || pc_write || reg_write ||
            state_o != S_HALT) hviol = 1'b1;
        step();
      end
      chk("halt_20cyc", hviol, 1'b0);
    end
    rst_n = 1'b0; #2; rst_n = 1'b1; #1;
    opcode = OP_J;
    chk("halt_rst", {state_o, active}, {S_FETCH, 1'b1});
    chk("halt_rst_ret", retired, 32'd0);

    // reset during an SW memory stall aborts it
    run_instr(OP_J, 0, 0, cyc);
    opcode = OP_SW;
    step(); step(); step();
    waitrequest = 1'b1;
    #1;
    chk("sw_mem", {state_o, mem_write, mem_read}, {S_MEM, 1'b1, 1'b0});
    chk("sw_pre_ret", retired, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sw_abort_mw", mem_write, 1'b0);
    chk("sw_abort_ret", retired, 32'd0);
    step();
    chk("sw_abort_rd", {mem_read, state_o}, {1'b0, S_FETCH});
    waitrequest = 1'b0;
    rst_n = 1'b1;
    #1;

    // retired wraps
    opcode = OP_J;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    chk("wrap_pre", retired, 32'hFFFF_FFFF);
    run_instr(OP_J, 0, 0, cyc);
    chk("wrap_post", retired, 32'd0);
    chk("wrap_cyc", cyc, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
